audio_sample_fifo: RTL and testbench
====================================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 SHALL provide parameter DEPTH_LOG2, default 4, log2 of stereo entry count (16 entries).
REQ-002 SHALL provide parameter PRIME_LEVEL, default 8, occupancy needed to leave PRIME; legal range 1..2^DEPTH_LOG2.
REQ-003 SHALL provide port clk_1p536m  input  1  sole clock, the PT8211 bit clock; all logic on rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port wr_valid  input  1  producer offers one stereo sample.
REQ-006 SHALL provide port wr_left  input  16  left sample, two's complement.
REQ-007 SHALL provide port wr_right  input  16  right sample, two's complement.
REQ-008 SHALL provide port wr_ready  output  1  high when the FIFO accepts a write.
REQ-009 SHALL provide port req  input  1  one-cycle sample request from the PT8211 serializer.
REQ-010 SHALL provide port idata_left  output  16  registered left sample to the serializer.
REQ-011 SHALL provide port idata_right  output  16  registered right sample to the serializer.
REQ-012 SHALL provide port level  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
REQ-013 SHALL provide port running  output  1  high in RUN state.
REQ-014 SHALL provide port underrun_cnt  output  16  number of underruns since reset.

Function
REQ-015 SHALL store {left,right} pairs in a circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo 2^DEPTH_LOG2.
REQ-016 SHALL drive wr_ready = (level != 2^DEPTH_LOG2), combinationally from registered level; a pop in the same cycle does not raise wr_ready.
REQ-017 SHALL accept a write when wr_valid && wr_ready; it advances the write pointer, and level increments unless a pop occurs in the same cycle.
REQ-018 SHALL implement a two-state FSM: PRIME (reset state) and RUN.
REQ-019 SHALL move PRIME->RUN on the edge where registered level >= PRIME_LEVEL; req in that same cycle is still handled as PRIME.
REQ-020 In PRIME, a req SHALL NOT pop, SHALL NOT count an underrun, and SHALL load idata_left/idata_right with 0 on the next edge.
REQ-021 In RUN, a req with level != 0 SHALL pop the head entry; idata_left/idata_right show it after exactly one clock edge and hold until the next req.
REQ-022 In RUN, a req with level == 0 is an underrun: SHALL increment underrun_cnt (saturating at 16'hFFFF), move to PRIME, and apply the output rule in REQ-030.
REQ-023 A simultaneous write and underrun req with level == 0 SHALL store the written sample (level becomes 1); no fall-through to the outputs.
REQ-024 A simultaneous write and pop with 0 < level < full SHALL leave level unchanged and advance both pointers.
REQ-025 Outputs SHALL change only on req or reset; no change without req.
REQ-026 running SHALL equal (state == RUN), registered.

Reset
REQ-027 Assertion of rst_n low SHALL immediately clear the pointers, level, underrun_cnt, idata_left, idata_right and running, and set state to PRIME, even mid-stream.
REQ-028 Buffer contents are not reset; data stored before reset SHALL never be popped after reset.
REQ-029 The first write SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro UNDERRUN_MUTE_EN: when defined, an underrun SHALL load 0 into idata_left/idata_right; when undefined, an underrun SHALL hold the last output values. Either way, the FSM enters PRIME and PRIME reqs then output 0 per REQ-020.

Verification
REQ-031 Reset, write 7 samples, pulse req -> running=0, level=7, outputs 0, underrun_cnt=0.
REQ-032 Write 8 samples (L=n, R=-n, n=1..8), then 8 reqs 32 cycles apart -> running=1, outputs 1/-1 … 8/-8 each one edge after req, level 8->0.
REQ-033 Fill 16 with wr_valid held high -> wr_ready=0 at level 16, 17th sample dropped; pop+write in same cycle at full -> write refused, level 15.
REQ-034 In RUN, level 0, req -> underrun_cnt=1, running=0; outputs 0 with UNDERRUN_MUTE_EN, last sample held without it.
REQ-035 Force underrun_cnt to 16'hFFFF, cause an underrun -> stays 16'hFFFF; with level 0, write plus req in the same cycle -> level=1, outputs not the new sample.
REQ-036 Assert rst_n low mid-stream at level 5 -> level=0, outputs 0, running=0 without waiting for a clock edge.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO feeding a PT8211 serializer: PRIME until PRIME_LEVEL entries, then pops on req; outputs update one edge after req.
// Producer is backpressured only at full (wr_ready); underrun returns to PRIME. Optional macro: UNDERRUN_MUTE_EN (mute on underrun).
module audio_sample_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                  clk_1p536m,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [15:0]           wr_left,
  input  logic [15:0]           wr_right,
  output logic                  wr_ready,
  input  logic                  req,
  output logic [15:0]           idata_left,
  output logic [15:0]           idata_right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  running,
  output logic [15:0]           underrun_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PRIME_LVL = (DEPTH_LOG2+1)'(PRIME_LEVEL);

  if (PRIME_LEVEL < 1 || PRIME_LEVEL > DEPTH) begin : g_bad_prime
    $error("PRIME_LEVEL must be within 1..2**DEPTH_LOG2");
  end

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2:0]   level_d;
  logic [31:0]           idata_d;
  logic [15:0]           underrun_cnt_d;
  logic                  push;
  logic                  pop;
  logic                  underrun;
  logic                  prime_req;

  assign wr_ready = (level != FULL_LVL);
  assign push     = wr_valid && wr_ready;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    underrun  = 1'b0;
    prime_req = 1'b0;
    case (state_q)
      ST_PRIME: begin
        prime_req = req;
        if (level >= PRIME_LVL) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req) begin
          if (level != '0) begin
            pop = 1'b1;
          end else begin
            underrun = 1'b1;
            state_d  = ST_PRIME;
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  // A write racing an underrun is only stored; it never reaches the outputs this cycle.
  always_comb begin
    idata_d = {idata_left, idata_right};
    if (prime_req) begin
      idata_d = '0;
    end else if (pop) begin
      idata_d = mem[rd_ptr];
    end else if (underrun) begin
`ifdef UNDERRUN_MUTE_EN
      idata_d = '0;
`else
      idata_d = {idata_left, idata_right};
`endif
    end
  end

  always_comb begin
    level_d = level;
    case ({push, pop})
      2'b10:   level_d = level + 1'b1;
      2'b01:   level_d = level - 1'b1;
      default: level_d = level;
    endcase
  end

  always_comb begin
    underrun_cnt_d = underrun_cnt;
    if (underrun && underrun_cnt != 16'hFFFF) begin
      underrun_cnt_d = underrun_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_1p536m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PRIME;
      running      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      underrun_cnt <= '0;
      idata_left   <= '0;
      idata_right  <= '0;
    end else begin
      state_q      <= state_d;
      running      <= (state_d == ST_RUN);
      level        <= level_d;
      underrun_cnt <= underrun_cnt_d;
      {idata_left, idata_right} <= idata_d;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; pointer reset alone keeps stale entries unreachable.
  always_ff @(posedge clk_1p536m) begin
    if (push) begin
      mem[wr_ptr] <= {wr_left, wr_right};
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: expected outputs queued per req, checked by a separate monitor.
module tb_audio_sample_fifo;

`ifdef UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic        clk_1p536m = 1'b0;
  logic        rst_n      = 1'b0;
  logic        wr_valid   = 1'b0;
  logic [15:0] wr_left    = '0;
  logic [15:0] wr_right   = '0;
  logic        wr_ready;
  logic        req        = 1'b0;
  logic [15:0] idata_left;
  logic [15:0] idata_right;
  logic [4:0]  level;
  logic        running;
  logic [15:0] underrun_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  audio_sample_fifo #(.DEPTH_LOG2(4), .PRIME_LEVEL(8)) dut (
    .clk_1p536m  (clk_1p536m),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_left     (wr_left),
    .wr_right    (wr_right),
    .wr_ready    (wr_ready),
    .req         (req),
    .idata_left  (idata_left),
    .idata_right (idata_right),
    .level       (level),
    .running     (running),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk_1p536m = ~clk_1p536m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pair(input int n);
    logic [15:0] l;
    logic [15:0] r;
    l = 16'(n);
    r = 16'(-n);
    return {l, r};
  endfunction

  task automatic wr(input int n);
    wr_valid = 1'b1;
    wr_left  = 16'(n);
    wr_right = 16'(-n);
    @(negedge clk_1p536m);
    wr_valid = 1'b0;
  endtask

  task automatic rq(input logic [31:0] e);
    exp_q.push_back(e);
    req = 1'b1;
    @(negedge clk_1p536m);
    req = 1'b0;
  endtask

  task automatic wr_rq(input int n, input logic [31:0] e);
    exp_q.push_back(e);
    wr_valid = 1'b1;
    wr_left  = 16'(n);
    wr_right = 16'(-n);
    req      = 1'b1;
    @(negedge clk_1p536m);
    wr_valid = 1'b0;
    req      = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk_1p536m);
  endtask

  // Monitor: every sampled req must produce the queued value one edge later.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk_1p536m);
      if (req && rst_n) begin
        @(negedge clk_1p536m);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL idata_unexpected_req: got %0h expected no req", {idata_left, idata_right});
        end else begin
          e = exp_q.pop_front();
          check("idata", {idata_left, idata_right}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(2);
    check("rst_level", 32'(level), 0);
    check("rst_running", 32'(running), 0);
    check("rst_idata", {idata_left, idata_right}, 0);
    check("rst_ucnt", 32'(underrun_cnt), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    rst_n = 1'b1;

    // Seven samples: still priming, req outputs zero
    for (int n = 1; n <= 7; n++) wr(n);
    check("prime_level7", 32'(level), 7);
    rq(32'h0);
    check("prime_running", 32'(running), 0);
    check("prime_level_after_req", 32'(level), 7);
    check("prime_ucnt", 32'(underrun_cnt), 0);

    // Eighth sample primes; drain with spaced reqs
    wr(8);
    check("level8", 32'(level), 8);
    idle(1);
    check("run_running", 32'(running), 1);
    for (int n = 1; n <= 8; n++) begin
      rq(pair(n));
      check("drain_level", 32'(level), 32'(8 - n));
      idle(31);
      check("hold", {idata_left, idata_right}, pair(n));
    end

    // Underrun in RUN at level 0
    rq(MUTE ? 32'h0 : pair(8));
    check("underrun_cnt1", 32'(underrun_cnt), 1);
    check("underrun_running", 32'(running), 0);
    rq(32'h0);
    check("after_underrun_level", 32'(level), 0);

    // Fill to full with wr_valid held; 17th sample dropped
    wr_valid = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      wr_left  = 16'(100 + i);
      wr_right = 16'(-(100 + i));
      @(negedge clk_1p536m);
    end
    wr_valid = 1'b0;
    check("full_level", 32'(level), 16);
    check("full_wr_ready", 32'(wr_ready), 0);
    check("full_running", 32'(running), 1);
    wr_rq(999, pair(100));
    check("full_pop_write_level", 32'(level), 15);
    for (int n = 101; n <= 110; n++) rq(pair(n));
    check("level5", 32'(level), 5);
    wr_rq(200, pair(111));
    check("pop_write_level", 32'(level), 5);
    for (int n = 112; n <= 115; n++) rq(pair(n));
    rq(pair(200));
    check("drained_level", 32'(level), 0);
    check("drained_running", 32'(running), 1);

    // Write racing an underrun: stored, not output
    wr_rq(300, MUTE ? 32'h0 : pair(200));
    check("race_level", 32'(level), 1);
    check("race_ucnt", 32'(underrun_cnt), 2);
    check("race_running", 32'(running), 0);
    rq(32'h0);

    // Counter saturation
    force dut.underrun_cnt = 16'hFFFF;
    #1;
    release dut.underrun_cnt;
    for (int n = 301; n <= 307; n++) wr(n);
    idle(1);
    check("sat_running", 32'(running), 1);
    for (int n = 300; n <= 307; n++) rq(pair(n));
    check("sat_level", 32'(level), 0);
    rq(MUTE ? 32'h0 : pair(307));
    check("sat_ucnt", 32'(underrun_cnt), 32'h0000FFFF);
    check("sat_running_off", 32'(running), 0);

    // Asynchronous reset mid-stream at level 5
    for (int n = 400; n <= 407; n++) wr(n);
    idle(1);
    for (int n = 400; n <= 402; n++) rq(pair(n));
    check("pre_rst_level", 32'(level), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 0);
    check("arst_idata", {idata_left, idata_right}, 0);
    check("arst_running", 32'(running), 0);
    check("arst_ucnt", 32'(underrun_cnt), 0);
    @(negedge clk_1p536m);
    @(negedge clk_1p536m);
    rst_n = 1'b1;

    // Stale entries never reappear after reset
    for (int n = 500; n <= 507; n++) wr(n);
    idle(1);
    check("post_rst_running", 32'(running), 1);
    rq(pair(500));
    check("post_rst_level", 32'(level), 7);

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
